// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side signal bundle of the parametrised single-clock FIFO.
// Clock and reset stay outside the bundle as plain ports of the FIFO.
interface sync_fifo_param_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic [DWIDTH-1:0] d_in;
    logic              wr;
    logic              rd;
    logic              flush;
    logic              clr_err;
    logic [DWIDTH-1:0] d_out;
    logic              d_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [AWIDTH:0]   count;
    logic              ov_flw;
    logic              ud_flw;

    // Handshake: wr is taken on a clock edge only when full is low before that
    // edge, rd only when empty is low; a refused request raises a sticky error.
    modport master (
        output d_in, wr, rd, flush, clr_err,
        input  d_out, d_valid, empty, full, almost_empty, almost_full, count, ov_flw, ud_flw
    );
    modport slave (
        input  d_in, wr, rd, flush, clr_err,
        output d_out, d_valid, empty, full, almost_empty, almost_full, count, ov_flw, ud_flw
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with parametrised width/depth, thresholds, sticky errors, flush
// and a choice of registered (FWFT=0) or first-word-fall-through (FWFT=1) read port.
module sync_fifo_param #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 8,
    parameter int AF_LEVEL = 192,
    parameter int AE_LEVEL = 64,
    parameter int FWFT     = 0
) (
    input logic              clk_in,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] AF_CNT = AF_LEVEL[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_CNT = AE_LEVEL[AWIDTH:0];

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_w;
    logic              empty_w, full_w;
    logic              wr_acc, rd_acc;
    logic              ov_q, ov_d;
    logic              ud_q, ud_d;

    // Extra pointer MSB is the wrap bit, so full and empty stay distinguishable.
    always_comb begin
        count_w  = wr_ptr_q - rd_ptr_q;
        empty_w  = (wr_ptr_q == rd_ptr_q);
        full_w   = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                   (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
        wr_acc   = bus.wr & ~full_w & ~bus.flush;
        rd_acc   = bus.rd & ~empty_w & ~bus.flush;
        wr_ptr_d = bus.flush ? '0 : wr_ptr_q + {{AWIDTH{1'b0}}, wr_acc};
        rd_ptr_d = bus.flush ? '0 : rd_ptr_q + {{AWIDTH{1'b0}}, rd_acc};
        // A new error in the same cycle as clr_err wins; flush suppresses errors.
        ov_d     = (bus.wr & full_w & ~bus.flush) | (ov_q & ~bus.clr_err);
        ud_d     = (bus.rd & empty_w & ~bus.flush) | (ud_q & ~bus.clr_err);
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ov_q     <= 1'b0;
            ud_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ov_q     <= ov_d;
            ud_q     <= ud_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst && wr_acc) begin
            mem_q[wr_ptr_q[AWIDTH-1:0]] <= bus.d_in;
        end
    end

    assign bus.count        = count_w;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (count_w <= AE_CNT);
    assign bus.almost_full  = (count_w >= AF_CNT);
    assign bus.ov_flw       = ov_q;
    assign bus.ud_flw       = ud_q;

    generate
        if (FWFT == 0) begin : g_std
            logic [DWIDTH-1:0] d_out_q, d_out_d;
            logic              d_valid_q, d_valid_d;

            always_comb begin
                d_out_d   = d_out_q;
                d_valid_d = rd_acc;
                if (rd_acc) begin
                    d_out_d = mem_q[rd_ptr_q[AWIDTH-1:0]];
                end
            end

            always_ff @(posedge clk_in) begin
                if (!rst) begin
                    d_out_q   <= '0;
                    d_valid_q <= 1'b0;
                end else begin
                    d_out_q   <= d_out_d;
                    d_valid_q <= d_valid_d;
                end
            end

            assign bus.d_out   = d_out_q;
            assign bus.d_valid = d_valid_q;
        end else begin : g_fwft
            // Head word is presented directly; driven to zero while nothing is stored.
            assign bus.d_out   = empty_w ? '0 : mem_q[rd_ptr_q[AWIDTH-1:0]];
            assign bus.d_valid = ~empty_w;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: default 8x256 registered-read FIFO against a count/queue
// model, plus a 16x8 FWFT FIFO driven from a vector table and a scoreboard fill/drain.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DWIDTH(8),  .AWIDTH(8)) bus0 ();
    sync_fifo_param_if #(.DWIDTH(16), .AWIDTH(3)) bus1 ();

    sync_fifo_param #(.DWIDTH(8), .AWIDTH(8), .AF_LEVEL(192), .AE_LEVEL(64), .FWFT(0)) dut0 (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus0)
    );

    sync_fifo_param #(.DWIDTH(16), .AWIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] exp1_q[$];
    int          m_cnt;
    logic        m_ov, m_ud;
    logic [7:0]  m_last;

    typedef struct {
        logic        w, r, f, c;
        logic [15:0] d;
        logic [3:0]  cnt;
        logic        emp, dv, ov, ud;
        logic [15:0] dout;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_ov   = 1'b0;
        m_ud   = 1'b0;
        m_last = 8'h00;
        exp_q.delete();
    endtask

    // One clock on the default FIFO, then compare everything against the model.
    task automatic cyc0(input logic w, input logic r, input logic f, input logic c, input logic [7:0] d);
        logic wa, ra;
        wa = w && !f && (m_cnt != 256);
        ra = r && !f && (m_cnt != 0);
        bus0.wr = w; bus0.rd = r; bus0.flush = f; bus0.clr_err = c; bus0.d_in = d;
        @(posedge clk);
        #1;
        m_ov = (!f && w && (m_cnt == 256)) || (m_ov && !c);
        m_ud = (!f && r && (m_cnt == 0)) || (m_ud && !c);
        if (f) begin
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (ra) begin
                m_last = exp_q.pop_front();
                m_cnt--;
            end
            if (wa) begin
                exp_q.push_back(d);
                m_cnt++;
            end
        end
        check("status0", {bus0.count, bus0.empty, bus0.full, bus0.almost_empty, bus0.almost_full,
                          bus0.ov_flw, bus0.ud_flw, bus0.d_valid},
              {9'(m_cnt), m_cnt == 0, m_cnt == 256, m_cnt <= 64, m_cnt >= 192, m_ov, m_ud, ra});
        check(ra ? "rd_data0" : "hold0", {24'h0, bus0.d_out}, {24'h0, m_last});
        bus0.wr = 1'b0; bus0.rd = 1'b0; bus0.flush = 1'b0; bus0.clr_err = 1'b0;
    endtask

    task automatic cyc1(input logic w, input logic r, input logic f, input logic c, input logic [15:0] d);
        bus1.wr = w; bus1.rd = r; bus1.flush = f; bus1.clr_err = c; bus1.d_in = d;
        @(posedge clk);
        #1;
        bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.flush = 1'b0; bus1.clr_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d16;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h5555, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5555};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hA0A0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA0A0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA0A0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001};

        // Reset held with requests active must leave both FIFOs empty.
        bus0.d_in = 8'h5A; bus0.flush = 1'b0; bus0.clr_err = 1'b0; bus0.wr = 1'b1; bus0.rd = 1'b1;
        bus1.d_in = 16'h5A5A; bus1.flush = 1'b0; bus1.clr_err = 1'b0; bus1.wr = 1'b1; bus1.rd = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus0.wr = 1'b0; bus0.rd = 1'b0; bus1.wr = 1'b0; bus1.rd = 1'b0;
        check("reset0", {bus0.count, bus0.empty, bus0.full, bus0.almost_empty, bus0.almost_full,
                         bus0.ov_flw, bus0.ud_flw, bus0.d_valid, bus0.d_out},
              {9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        check("reset1", {bus1.count, bus1.empty, bus1.full, bus1.ov_flw, bus1.ud_flw, bus1.d_valid},
              {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        model_reset();

        // Fill 0x00..0xFF, then one write too many.
        for (int i = 0; i < 256; i++) cyc0(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        cyc0(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        // Drain all, then one read too many.
        for (int i = 0; i < 256; i++) cyc0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc0(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Pointer wrap, then concurrent traffic at steady state.
        for (int i = 0; i < 200; i++) cyc0(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 200; i++) cyc0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) cyc0(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
        cyc0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc0(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // rd+wr at empty and at full, clr_err, flush with requests, set-over-clear.
        cyc0(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        for (int i = 0; i < 255; i++) cyc0(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
        cyc0(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        cyc0(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cyc0(1'b1, 1'b1, 1'b1, 1'b0, 8'h33);
        cyc0(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        cyc0(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Reset mid-burst discards stored words.
        for (int i = 0; i < 3; i++) cyc0(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + i));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cyc0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // FWFT table on the small FIFO.
        for (int i = 0; i < 12; i++) begin
            cyc1(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].c, tbl[i].d);
            check($sformatf("vec%0d_count", i), {28'h0, bus1.count}, {28'h0, tbl[i].cnt});
            check($sformatf("vec%0d_flags", i), {bus1.empty, bus1.d_valid, bus1.ov_flw, bus1.ud_flw},
                  {tbl[i].emp, tbl[i].dv, tbl[i].ov, tbl[i].ud});
            if (tbl[i].dv) check($sformatf("vec%0d_dout", i), {16'h0, bus1.d_out}, {16'h0, tbl[i].dout});
        end

        // FWFT fill to full with thresholds, overflow, rd+wr at full, drain.
        cyc1(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        exp1_q.delete();
        for (int i = 0; i < 8; i++) begin
            d16 = 16'($urandom_range(0, 65535));
            exp1_q.push_back(d16);
            cyc1(1'b1, 1'b0, 1'b0, 1'b0, d16);
            check("fill1_flags", {bus1.count, bus1.full, bus1.almost_full, bus1.almost_empty},
                  {4'(i + 1), i == 7, (i + 1) >= 6, (i + 1) <= 2});
            check("fill1_head", {16'h0, bus1.d_out}, {16'h0, exp1_q[0]});
        end
        cyc1(1'b1, 1'b0, 1'b0, 1'b0, 16'hDEAD);
        check("ovf1", {bus1.count, bus1.ov_flw}, {4'd8, 1'b1});
        void'(exp1_q.pop_front());
        cyc1(1'b1, 1'b1, 1'b0, 1'b0, 16'hDEAD);
        check("rdwr_full1", {bus1.count, bus1.ov_flw, bus1.d_out}, {4'd7, 1'b1, exp1_q[0]});
        while (exp1_q.size() > 0) begin
            check("drain1_head", {15'h0, bus1.d_valid, bus1.d_out}, {15'h0, 1'b1, exp1_q[0]});
            void'(exp1_q.pop_front());
            cyc1(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        end
        check("drain1_end", {bus1.count, bus1.empty, bus1.d_valid, bus1.ud_flw}, {4'd0, 1'b1, 1'b0, 1'b0});
        cyc1(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check("clr1", {bus1.ov_flw, bus1.ud_flw}, {1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
